// File: rtl/c_frag_pkg.sv
// rtl/c_frag_pkg.sv - shared sizing helpers and latency encodings for the C-fragment pipe
package c_frag_pkg;

    localparam int LAT_COMB = 0;
    localparam int LAT_OUT  = 1;
    localparam int LAT_MID  = 2;

    function automatic int nin(input int nsel);
        return 2 ** nsel;
    endfunction

    function automatic int mask_w(input int nsel);
        return 2 * (2 ** nsel);
    endfunction

endpackage

// File: rtl/c_frag_half.sv
// rtl/c_frag_half.sv - one C-fragment half: per-input inversion followed by an input mux
// Ports: a   - packed inputs, input i at [i*WIDTH +: WIDTH]
//        sel - input select
//        inv - per-input inversion mask
//        z   - selected (possibly inverted) lane
module c_frag_half
    import c_frag_pkg::*;
#(
    parameter int NSEL  = 2,
    parameter int WIDTH = 1
) (
    input  logic [nin(NSEL)*WIDTH-1:0] a,
    input  logic [NSEL-1:0]            sel,
    input  logic [nin(NSEL)-1:0]       inv,
    output logic [WIDTH-1:0]           z
);

    localparam int NIN = nin(NSEL);

    always_comb begin
        z = '0;
        for (int i = 0; i < NIN; i++) begin
            if (sel == NSEL'(i)) begin
                z = a[i*WIDTH +: WIDTH] ^ {WIDTH{inv[i]}};
            end
        end
    end

endmodule

// File: rtl/c_frag_pipe.sv
// rtl/c_frag_pipe.sv - pipelined C fragment: two inverting muxes, final select, serial mask chain
// Ports: QCK/QRT_N clock and sync active-low reset; QEN pipeline advance;
//        IN_VALID/TA/BA/TSEL/BSEL/TBS input vector; CFG_EN/CFG_DI/CFG_DO mask shift chain;
//        TZ/CZ/OUT_VALID results.
module c_frag_pipe
    import c_frag_pkg::*;
#(
    parameter int                        NSEL     = 2,
    parameter int                        WIDTH    = 1,
    parameter int                        LAT      = 1,
    parameter logic [mask_w(NSEL)-1:0]   INV_INIT = '0
) (
    input  logic                         QCK,
    input  logic                         QRT_N,
    input  logic                         QEN,
    input  logic                         IN_VALID,
    input  logic [nin(NSEL)*WIDTH-1:0]   TA,
    input  logic [nin(NSEL)*WIDTH-1:0]   BA,
    input  logic [NSEL-1:0]              TSEL,
    input  logic [NSEL-1:0]              BSEL,
    input  logic                         TBS,
    input  logic                         CFG_EN,
    input  logic                         CFG_DI,
    output logic                         CFG_DO,
    output logic [WIDTH-1:0]             TZ,
    output logic [WIDTH-1:0]             CZ,
    output logic                         OUT_VALID
);

    localparam int NIN = nin(NSEL);
    localparam int MW  = mask_w(NSEL);

    if (NSEL < 1 || NSEL > 4) begin : g_bad_nsel
        $error("c_frag_pipe: NSEL must be 1..4");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("c_frag_pipe: WIDTH must be 1..32");
    end
    if (LAT < LAT_COMB || LAT > LAT_MID) begin : g_bad_lat
        $error("c_frag_pipe: LAT must be 0..2");
    end

    // Config chain shifts regardless of QEN so the mask can be loaded while the pipe is stalled.
    logic [MW-1:0] mask;

    always_ff @(posedge QCK) begin
        if (!QRT_N) begin
            mask <= INV_INIT;
        end else if (CFG_EN) begin
            mask <= {mask[MW-2:0], CFG_DI};
        end
    end

    assign CFG_DO = mask[MW-1];

    // Inputs presented during a config shift are dropped so no vector sees a half-loaded mask.
    logic             acc;
    logic [WIDTH-1:0] tz_c;
    logic [WIDTH-1:0] bz_c;

    assign acc = IN_VALID & ~CFG_EN;

    c_frag_half #(.NSEL(NSEL), .WIDTH(WIDTH)) u_top (
        .a   (TA),
        .sel (TSEL),
        .inv (mask[NIN-1:0]),
        .z   (tz_c)
    );

    c_frag_half #(.NSEL(NSEL), .WIDTH(WIDTH)) u_bot (
        .a   (BA),
        .sel (BSEL),
        .inv (mask[MW-1:NIN]),
        .z   (bz_c)
    );

    if (LAT == LAT_COMB) begin : g_comb
        assign TZ        = tz_c;
        assign CZ        = TBS ? bz_c : tz_c;
        assign OUT_VALID = acc;
    end else if (LAT == LAT_OUT) begin : g_out
        logic [WIDTH-1:0] tz_q;
        logic [WIDTH-1:0] cz_q;
        logic             v_q;

        always_ff @(posedge QCK) begin
            if (!QRT_N) begin
                tz_q <= '0;
                cz_q <= '0;
                v_q  <= 1'b0;
            end else if (QEN) begin
                tz_q <= tz_c;
                cz_q <= TBS ? bz_c : tz_c;
                v_q  <= acc;
            end
        end

        assign TZ        = tz_q;
        assign CZ        = cz_q;
        assign OUT_VALID = v_q;
    end else begin : g_mid
        // Stage 1 keeps both half results and the final select; the top/bottom mux is stage 2.
        logic [WIDTH-1:0] s1_tz;
        logic [WIDTH-1:0] s1_bz;
        logic             s1_tbs;
        logic             s1_v;
        logic [WIDTH-1:0] s2_tz;
        logic [WIDTH-1:0] s2_cz;
        logic             s2_v;

        always_ff @(posedge QCK) begin
            if (!QRT_N) begin
                s1_tz  <= '0;
                s1_bz  <= '0;
                s1_tbs <= 1'b0;
                s1_v   <= 1'b0;
                s2_tz  <= '0;
                s2_cz  <= '0;
                s2_v   <= 1'b0;
            end else if (QEN) begin
                s1_tz  <= tz_c;
                s1_bz  <= bz_c;
                s1_tbs <= TBS;
                s1_v   <= acc;
                s2_tz  <= s1_tz;
                s2_cz  <= s1_tbs ? s1_bz : s1_tz;
                s2_v   <= s1_v;
            end
        end

        assign TZ        = s2_tz;
        assign CZ        = s2_cz;
        assign OUT_VALID = s2_v;
    end

endmodule
